// File: rtl/alu_16.sv
// alu_16: signed 16-bit multi-cycle ALU with a start/done handshake.
//   Add/sub finish one edge after acceptance. Mul (shift-add) and div
//   (restoring) run WIDTH iterations on operand magnitudes and then apply the sign.
//   Optional feature macro: ALU16_LOGIC_OPS_EN enables the AND/OR/XOR/NOT opcodes (1xx).
//   When the macro is undefined, 1xx opcodes complete with result 0.
module alu_16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [2:0]              opcode,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   output logic signed [WIDTH-1:0] result,
   output logic                    done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
      OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_NOT = 3'b111
   } op_t;

   state_t           state_q;
   op_t              op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             neg_q;
   logic [CW-1:0]    cnt_q;
   // Multiply datapath: only the low WIDTH product bits are ever returned, and
   // low bits of a sum depend only on low bits of its addends, so the
   // accumulator and shifted multiplicand are kept WIDTH bits wide.
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   // Divide datapath: partial remainder, dividend shifting into quotient, divisor.
   logic [WIDTH-1:0] rem_q, dvd_q, dvsr_q;
   logic [WIDTH-1:0] result_q;
   logic             done_q;

   logic [WIDTH-1:0] mul_sum_d;
   logic [WIDTH:0]   div_shift_d;
   logic [WIDTH-1:0] div_sub_d;
   logic             div_ge_d;
   logic [WIDTH-1:0] single_d, mul_res_d, div_res_d;
   logic             iter_op_d;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
   endfunction

   // Per-iteration datapath values and final results for every opcode.
   always_comb begin
      mul_sum_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      div_shift_d = {rem_q, dvd_q[WIDTH-1]};
      div_ge_d    = (div_shift_d >= {1'b0, dvsr_q});
      // When the trial subtraction succeeds the difference is below the divisor,
      // so the low WIDTH bits hold it exactly.
      div_sub_d   = div_shift_d[WIDTH-1:0] - dvsr_q;
      iter_op_d   = (op_q == OP_MUL) || (op_q == OP_DIV);
      mul_res_d   = neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
      if (b_q == '0)
         div_res_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         div_res_d = neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
      single_d = '0;
      case (op_q)
         OP_ADD:  single_d = a_q + b_q;
         OP_SUB:  single_d = a_q - b_q;
`ifdef ALU16_LOGIC_OPS_EN
         OP_AND:  single_d = a_q & b_q;
         OP_OR:   single_d = a_q | b_q;
         OP_XOR:  single_d = a_q ^ b_q;
         OP_NOT:  single_d = ~a_q;
`endif
         default: single_d = '0;
      endcase
   end

   // Control FSM with registered result/done and iterative mul/div datapath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvsr_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_FINISH: begin
               if (start) begin
                  op_q     <= op_t'(opcode);
                  a_q      <= A;
                  b_q      <= B;
                  neg_q    <= A[WIDTH-1] ^ B[WIDTH-1];
                  cnt_q    <= '0;
                  acc_q    <= '0;
                  mcand_q  <= mag(A);
                  mplier_q <= mag(B);
                  rem_q    <= '0;
                  dvd_q    <= mag(A);
                  dvsr_q   <= mag(B);
                  done_q   <= 1'b0;
                  state_q  <= S_CALC;
               end
            end
            S_CALC: begin
               if (!iter_op_d) begin
                  result_q <= single_d;
                  done_q   <= 1'b1;
                  state_q  <= S_FINISH;
               end else if (cnt_q == CW'(WIDTH)) begin
                  result_q <= (op_q == OP_MUL) ? mul_res_d : div_res_d;
                  done_q   <= 1'b1;
                  state_q  <= S_FINISH;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  if (op_q == OP_MUL) begin
                     acc_q    <= mul_sum_d;
                     mcand_q  <= mcand_q << 1;
                     mplier_q <= mplier_q >> 1;
                  end else begin
                     rem_q <= div_ge_d ? div_sub_d : div_shift_d[WIDTH-1:0];
                     dvd_q <= {dvd_q[WIDTH-2:0], div_ge_d};
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule

// File: tb/tb_alu_16.sv
// tb_alu_16: randomized and directed checks of alu_16 against a behavioural model.
module tb_alu_16;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [2:0]         opcode;
   logic signed [15:0] A, B;
   logic signed [15:0] result;
   logic               done;

   int checks   = 0;
   int failures = 0;

   alu_16 #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .A(A), .B(B), .result(result), .done(done)
   );

   always #5 clk = ~clk;

   // Reference value from plain integer arithmetic, truncated to 16 bits.
   function automatic logic [15:0] ref_op(input logic [2:0] op,
                                          input logic signed [15:0] a,
                                          input logic signed [15:0] b);
      int ai, bi, r;
      ai = a;
      bi = b;
      r  = 0;
      case (op)
         3'd0: r = ai + bi;
         3'd1: r = ai - bi;
         3'd2: r = ai * bi;
         3'd3: r = (bi == 0) ? ((ai >= 0) ? 32767 : -32768) : ai / bi;
`ifdef ALU16_LOGIC_OPS_EN
         3'd4: r = ai & bi;
         3'd5: r = ai | bi;
         3'd6: r = ai ^ bi;
         3'd7: r = ~ai;
`endif
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   function automatic int latency(input logic [2:0] op);
      return (op == 3'd2 || op == 3'd3) ? 17 : 1;
   endfunction

   // Cycle-level model: an accepted op becomes visible 'latency' edges later.
   logic        m_busy, m_done;
   int          m_left;
   logic [15:0] m_res, m_pend;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0;
         m_left <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_pend <= '0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end
         m_left <= m_left - 1;
      end else if (start) begin
         m_busy <= 1'b1;
         m_left <= latency(opcode);
         m_pend <= ref_op(opcode, A, B);
         m_done <= 1'b0;
      end
   end

   // Compare DUT against the model on every cycle out of reset.
   always @(negedge clk) begin
      if (reset) begin
         checks++;
         if (done !== m_done || result !== $signed(m_res)) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t done=%0b expected=%0b result=%0d expected=%0d",
                     $time, done, m_done, result, $signed(m_res));
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Issue one op from a negedge; scramble inputs after acceptance; wait (bounded) for done.
   task automatic run_op(input logic [2:0] op, input logic signed [15:0] a,
                         input logic signed [15:0] b, input bit pulses,
                         output int lat, output int res);
      int n;
      opcode = op; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      A      = 16'($urandom);
      B      = 16'($urandom);
      opcode = 3'($urandom);
      n = 0;
      while (!done && n < 40) begin
         if (pulses) start = (m_busy && m_left > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      lat = n;
      res = result;
   endtask

   task automatic chk_op(input string name, input logic [2:0] op, input int a, input int b,
                         input int exp_res, input int exp_lat);
      int lat, res;
      run_op(op, 16'(a), 16'(b), 1'b0, lat, res);
      chk({name, "_res"}, res, exp_res);
      chk({name, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      #1000000;
      failures++;
      $display("FAIL global_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int lat, res;
      int av [3] = '{-1200, -200, 800};
      int bv [2] = '{-90, 410};
      logic [2:0] op;
      logic signed [15:0] ra, rb;

      reset = 1'b0; start = 1'b0; opcode = '0; A = '0; B = '0;
      @(negedge clk);
      reset = 1'b1;
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      repeat (3) @(negedge clk);
      chk("idle_done", done, 0);

      chk_op("add", 3'd0, -1200, -90, -1290, 1);
      chk_op("sub", 3'd1, -1200, -90, -1110, 1);
      chk_op("mul", 3'd2, -1200, -90, -23072, 17);
      chk_op("div", 3'd3, -1200, -90, 13, 17);
      chk_op("mul_wrap", 3'd2, 800, 410, 320, 17);
      chk_op("div_neg", 3'd3, 800, -90, -8, 17);
      chk_op("div_trunc", 3'd3, -200, 410, 0, 17);
      chk_op("div_ovf", 3'd3, -32768, -1, -32768, 17);
      chk_op("div0_pos", 3'd3, 5, 0, 32767, 17);
      chk_op("div0_neg", 3'd3, -5, 0, -32768, 17);
`ifndef ALU16_LOGIC_OPS_EN
      chk_op("op1xx", 3'd5, 1234, 77, 0, 1);
`endif

      // Asynchronous reset at E8 of a multiply.
      opcode = 3'd2; A = 16'sd300; B = 16'sd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      @(negedge clk);
      reset = 1'b1;
      chk_op("after_rst", 3'd2, 300, 7, 2100, 17);

      // start pulse during CALC is ignored.
      opcode = 3'd2; A = 16'sd800; B = 16'sd410; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      opcode = 3'd0; A = 16'sd1; B = 16'sd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 4;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      chk("calc_pulse_lat", lat, 17);
      chk("calc_pulse_res", result, 320);

      // start held across FINISH restarts immediately; done drops at that edge.
      opcode = 3'd0; A = 16'sd3; B = 16'sd4; start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("held_done1", done, 1);
      chk("held_res1", result, 7);
      A = 16'sd10; B = 16'sd5;
      @(negedge clk);
      start = 1'b0;
      chk("held_drop", done, 0);
      chk("held_hold", result, 7);
      @(negedge clk);
      chk("held_done2", done, 1);
      chk("held_res2", result, 15);

      // Sweep of the listed operands for all four arithmetic ops.
      foreach (av[i]) foreach (bv[j]) for (int k = 0; k < 4; k++) begin
         op = 3'(k);
         ra = 16'(av[i]);
         rb = 16'(bv[j]);
         run_op(op, ra, rb, 1'b0, lat, res);
         chk("sweep_res", res, int'($signed(ref_op(op, ra, rb))));
         chk("sweep_lat", lat, latency(op));
      end

      // Random ops with corner-heavy operands and spurious start pulses in CALC.
      for (int t = 0; t < 200; t++) begin
         op = 3'($urandom_range(0, 7));
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: ra = -16'sd32768;
            1: rb = -16'sd1;
            2: rb = '0;
            3: begin ra = -16'sd32768; rb = -16'sd1; end
            default: ;
         endcase
         run_op(op, ra, rb, 1'b1, lat, res);
         chk("rand_res", res, int'($signed(ref_op(op, ra, rb))));
         chk("rand_lat", lat, latency(op));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
